uart_stream_ctrl: RTL
=====================

# uart_stream_ctrl

- Autonomous AXI4-Lite master that configures the 16550-style UART register block and then services it without CPU involvement.
- Bridges a byte-stream TX input and a byte-stream RX output onto the UART's AXI4-Lite slave port.
- Polls LSR and moves bytes through THR/RBR, arbitrating between TX and RX work with round-robin fairness.
- Sits between a streaming producer/consumer (e.g. a debug or boot loader engine) and the UART top.

## Interface
Parameters:
- DIVISOR, 16'd27: baud divisor written to {DLM, DLL}.
- LCR_VAL, 8'h03: line control value; DLAB (bit 7) is forced 0 in the final write.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_start  in  1  1-cycle pulse; starts configuration from IDLE only.
- cfg_done  out  1  high once configuration has completed; stays high until reset.
- err  out  1  sticky flag; set on any non-OKAY bresp/rresp; cleared only by reset.
- tx_data  in  8  byte to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transfer occurs when tx_valid && tx_ready.
- rx_data  out  8  received byte.
- rx_valid  out  1  rx_data is valid; held until accepted.
- rx_ready  in  1  transfer occurs when rx_valid && rx_ready.
- m_axi_awaddr/awvalid/awready  out/out/in  4/1/1  write address channel.
- m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  write data channel; wdata = {24'b0, byte}, wstrb = 4'b0001.
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  write response channel.
- m_axi_araddr/arvalid/arready  out/out/in  4/1/1  read address channel.
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  read data channel.

## Operation
- Addresses are UART register indices: 0 = THR/RBR, 1 = DLM (DLAB set), 3 = LCR, 5 = LSR; with DLAB set, 0 = DLL.
- States:
  - IDLE: waits for cfg_start, then goes to CFG.
  - CFG: four writes in order: LCR = LCR_VAL | 8'h80, DLL = DIVISOR[7:0], DLM = DIVISOR[15:8], LCR = LCR_VAL & 8'h7F. Sets cfg_done, then goes to POLL.
  - POLL: reads LSR and captures rdata[7:0], then goes to DECIDE.
  - DECIDE:
    - rx_elig = LSR[0] && !rx_valid.
    - tx_elig = LSR[5] && tx_valid.
    - Both eligible: serve the side not served last (last_srv register, reset = TX, so RX wins first).
    - Only one eligible: serve it.
    - Neither: return to POLL.
  - RDRX: reads addr 0; loads rx_data = rdata[7:0] and sets rx_valid; then POLL.
  - WRTX: pulses tx_ready for 1 cycle on entry, latches tx_data, writes it to addr 0, then POLL.
- Write transaction:
  - awvalid and wvalid assert together; each drops independently in the cycle after its ready is sampled high.
  - bready is high until bvalid is seen; the transaction completes on bvalid.
- Read transaction:
  - arvalid is held until arready is seen.
  - rready is high until rvalid is seen; data is captured on rvalid.
- Any bresp/rresp ≠ 2'b00 sets err. Sequencing continues regardless.
- rx_valid clears on the rx_ready handshake. A new RX read is never issued while rx_valid = 1, so no byte is ever overwritten.
- cfg_start outside IDLE is ignored.

## Timing
- Reset values:
  - All AXI valid/ready outputs 0; awaddr/araddr/wdata 0; wstrb 0.
  - tx_ready 0, rx_valid 0, rx_data 0, cfg_done 0, err 0, state IDLE.
- All outputs are registered. The first AXI valid asserts 1 cycle after entering a bus state.
- One idle cycle separates consecutive transactions (DECIDE, or the inter-write gap in CFG).
- Zero-wait slave (ready same cycle as valid, response the next cycle):
  - Write costs 3 cycles; read costs 3 cycles.
  - CFG completes in 16 cycles after cfg_start.
  - Steady TX loop (POLL + DECIDE + WRTX) is ≤ 8 cycles per byte.
- An awready/arready stall of any length holds addresses and data stable.
- Reset mid-transaction drops all valids immediately (asynchronous). The RX byte in flight is discarded.

## Test plan
- Reset, then cfg_start with DIVISOR = 16'h0102, LCR_VAL = 8'h1B -> writes (3,0x9B), (0,0x02), (1,0x01), (3,0x1B) in order; cfg_done rises after the 4th bvalid.
- LSR returns 0x60 with tx_valid and tx_data = 0x55 -> one tx_ready pulse, then write (0,0x55), then the next LSR poll.
- LSR returns 0x61 with rx_ready held 0 -> exactly one read of addr 0 and rx_valid = 1 with rx_data = RBR; subsequent polls issue no addr-0 reads until rx_ready = 1.
- LSR returns 0x61 repeatedly with tx_valid and rx_ready both held 1 -> services strictly alternate RX, TX, RX, TX.
- Slave returns bresp = 2'b10 on a THR write -> err = 1 and remains 1; polling continues.
- awready held low for 20 cycles, then reset asserted -> awvalid drops in the same cycle; state IDLE; cfg_done = 0.

Source files
------------

// File: rtl/uart_stream_ctrl.sv
// rtl/uart_stream_ctrl.sv - AXI4-Lite master that configures a 16550 UART and moves stream bytes through it
// Polls LSR and arbitrates TX/RX work round-robin; every output is registered.
module uart_stream_ctrl #(
  parameter logic [15:0] DIVISOR = 16'd27,
  parameter logic [7:0]  LCR_VAL = 8'h03
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_start,
  output logic        cfg_done,
  output logic        err,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [3:0]  m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [3:0]  m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_ISS, S_CFG_WAIT, S_CFG_GAP, S_POLL_ISS, S_POLL_WAIT,
    S_DECIDE, S_RDRX_ISS, S_RDRX_WAIT, S_WRTX_ISS, S_WRTX_WAIT
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  cfg_idx, cfg_idx_nxt;
  logic [7:0]  lsr, lsr_nxt;
  logic        last_rx, last_rx_nxt;
  logic        awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
  logic [3:0]  awaddr_nxt, araddr_nxt, wstrb_nxt;
  logic [31:0] wdata_nxt;
  logic        tx_ready_nxt, rx_valid_nxt, cfg_done_nxt, err_nxt;
  logic [7:0]  rx_data_nxt;
  logic [3:0]  cfg_addr;
  logic [7:0]  cfg_byte;
  logic        b_done, r_done, rx_elig, tx_elig, pick_rx, pick_tx;
  logic [23:0] unused_rdata_hi;

  assign unused_rdata_hi = m_axi_rdata[31:8];
  assign b_done  = m_axi_bvalid && m_axi_bready;
  assign r_done  = m_axi_rvalid && m_axi_rready;
  assign rx_elig = lsr[0] && !rx_valid;
  assign tx_elig = lsr[5] && tx_valid;
  // On a tie, last_rx decides: the side served last time yields.
  assign pick_rx = rx_elig && (!tx_elig || !last_rx);
  assign pick_tx = tx_elig && !pick_rx;

  always_comb begin
    cfg_addr = 4'd3;
    cfg_byte = LCR_VAL | 8'h80;
    case (cfg_idx)
      2'd1:    begin cfg_addr = 4'd0; cfg_byte = DIVISOR[7:0];      end
      2'd2:    begin cfg_addr = 4'd1; cfg_byte = DIVISOR[15:8];     end
      2'd3:    begin cfg_addr = 4'd3; cfg_byte = LCR_VAL & 8'h7F;   end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (cfg_start) state_nxt = S_CFG_ISS;
      S_CFG_ISS:   state_nxt = S_CFG_WAIT;
      S_CFG_WAIT:  if (b_done) state_nxt = (cfg_idx == 2'd3) ? S_POLL_ISS : S_CFG_GAP;
      S_CFG_GAP:   state_nxt = S_CFG_ISS;
      S_POLL_ISS:  state_nxt = S_POLL_WAIT;
      S_POLL_WAIT: if (r_done) state_nxt = S_DECIDE;
      S_DECIDE:    state_nxt = pick_rx ? S_RDRX_ISS : (pick_tx ? S_WRTX_ISS : S_POLL_ISS);
      S_RDRX_ISS:  state_nxt = S_RDRX_WAIT;
      S_RDRX_WAIT: if (r_done) state_nxt = S_POLL_ISS;
      S_WRTX_ISS:  state_nxt = S_WRTX_WAIT;
      S_WRTX_WAIT: if (b_done) state_nxt = S_POLL_ISS;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    awvalid_nxt  = m_axi_awvalid && !m_axi_awready;
    wvalid_nxt   = m_axi_wvalid && !m_axi_wready;
    bready_nxt   = m_axi_bready && !m_axi_bvalid;
    arvalid_nxt  = m_axi_arvalid && !m_axi_arready;
    rready_nxt   = m_axi_rready && !m_axi_rvalid;
    awaddr_nxt   = m_axi_awaddr;
    araddr_nxt   = m_axi_araddr;
    wdata_nxt    = m_axi_wdata;
    wstrb_nxt    = m_axi_wstrb;
    tx_ready_nxt = 1'b0;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = rx_valid && !rx_ready;
    cfg_done_nxt = cfg_done;
    err_nxt      = err || (b_done && m_axi_bresp != 2'b00) || (r_done && m_axi_rresp != 2'b00);
    cfg_idx_nxt  = cfg_idx;
    lsr_nxt      = lsr;
    last_rx_nxt  = last_rx;
    case (state)
      S_CFG_ISS, S_WRTX_ISS: begin
        awvalid_nxt = 1'b1;
        wvalid_nxt  = 1'b1;
        bready_nxt  = 1'b1;
        wstrb_nxt   = 4'b0001;
        awaddr_nxt  = (state == S_CFG_ISS) ? cfg_addr : 4'd0;
        wdata_nxt   = {24'h0, (state == S_CFG_ISS) ? cfg_byte : tx_data};
      end
      S_CFG_WAIT: if (b_done) begin
        cfg_idx_nxt = cfg_idx + 2'd1;
        if (cfg_idx == 2'd3) cfg_done_nxt = 1'b1;
      end
      S_POLL_ISS, S_RDRX_ISS: begin
        arvalid_nxt = 1'b1;
        rready_nxt  = 1'b1;
        araddr_nxt  = (state == S_POLL_ISS) ? 4'd5 : 4'd0;
      end
      S_POLL_WAIT: if (r_done) lsr_nxt = m_axi_rdata[7:0];
      S_DECIDE: begin
        if (pick_rx) last_rx_nxt = 1'b1;
        if (pick_tx) begin
          last_rx_nxt  = 1'b0;
          tx_ready_nxt = 1'b1;
        end
      end
      S_RDRX_WAIT: if (r_done) begin
        rx_data_nxt  = m_axi_rdata[7:0];
        rx_valid_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_awaddr  <= 4'd0;
      m_axi_araddr  <= 4'd0;
      m_axi_wdata   <= 32'd0;
      m_axi_wstrb   <= 4'd0;
      tx_ready      <= 1'b0;
      rx_data       <= 8'd0;
      rx_valid      <= 1'b0;
      cfg_done      <= 1'b0;
      err           <= 1'b0;
      cfg_idx       <= 2'd0;
      lsr           <= 8'd0;
      last_rx       <= 1'b0;
    end else begin
      m_axi_awvalid <= awvalid_nxt;
      m_axi_wvalid  <= wvalid_nxt;
      m_axi_bready  <= bready_nxt;
      m_axi_arvalid <= arvalid_nxt;
      m_axi_rready  <= rready_nxt;
      m_axi_awaddr  <= awaddr_nxt;
      m_axi_araddr  <= araddr_nxt;
      m_axi_wdata   <= wdata_nxt;
      m_axi_wstrb   <= wstrb_nxt;
      tx_ready      <= tx_ready_nxt;
      rx_data       <= rx_data_nxt;
      rx_valid      <= rx_valid_nxt;
      cfg_done      <= cfg_done_nxt;
      err           <= err_nxt;
      cfg_idx       <= cfg_idx_nxt;
      lsr           <= lsr_nxt;
      last_rx       <= last_rx_nxt;
    end
  end

endmodule
